fwd_scoreboard: RTL

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/fwd_port_match.sv | 36 +++
 rtl/fwd_scoreboard.sv | 83 ++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types for the forwarding scoreboard: stage indices,
// per-stage entry record, forward-select encoding and select-width helper.
package pipe_pkg;

  typedef enum int unsigned {
    STG_E = 0,
    STG_M = 1,
    STG_W = 2
  } stage_e;

  // fwd_sel value meaning "take the operand from the register file"
  localparam int unsigned FWD_RF = 0;

  typedef struct packed {
    logic       valid;
    logic [4:0] a3;
    logic [1:0] tnew;
  } entry_t;

  // Width of one fwd_sel field: register file plus one code per stage
  function automatic int unsigned fwd_sw(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_port_match.sv
// Match/priority logic for a single decode read port: finds the youngest
// in-flight writer of the source register and decides forward vs stall.
module fwd_port_match
  import pipe_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned SW    = fwd_sw(DEPTH)
) (
  input  entry_t [DEPTH-1:0] ent,
  input  logic [4:0]         addr,
  input  logic [1:0]         tuse,
  output logic [SW-1:0]      sel,
  output logic               stall_req
);

  logic found;

  // Scan from E outward; the first hit is the youngest writer and masks older ones
  always_comb begin
    sel       = SW'(FWD_RF);
    stall_req = 1'b0;
    found     = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (!found && ent[k].valid && (ent[k].a3 == addr) && (addr != 5'd0)) begin
        found = 1'b1;
        if (ent[k].tnew == 2'd0) begin
          sel = SW'(k + 1);
        end
        if (ent[k].tnew > tuse) begin
          stall_req = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding/hazard scoreboard: tracks destination registers of the
// post-decode stages, selects forward sources for each decode read port,
// and raises stall on unresolved data hazards or a busy mult/div unit.
module fwd_scoreboard
  import pipe_pkg::*;
#(
  parameter  int unsigned NRD     = 2,
  parameter  int unsigned DEPTH   = 3,
  parameter  int unsigned MUL_LAT = 5,
  parameter  int unsigned DIV_LAT = 10,
  localparam int unsigned SW      = fwd_sw(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              iss_we,
  input  logic [4:0]        iss_a3,
  input  logic [1:0]        iss_tnew,
  input  logic [NRD*5-1:0]  rd_addr,
  input  logic [NRD*2-1:0]  rd_tuse,
  input  logic              md_use,
  input  logic              md_start,
  input  logic              md_is_div,
  input  logic              flush_e,
  output logic [NRD*SW-1:0] fwd_sel,
  output logic              stall,
  output logic              md_busy
);

  localparam int unsigned MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int unsigned CW      = $clog2(MAX_LAT + 1);

  entry_t [DEPTH-1:0] ent;
  logic   [CW-1:0]    md_cnt;
  logic   [NRD-1:0]   port_stall;

  for (genvar p = 0; p < NRD; p++) begin : g_port
    fwd_port_match #(
      .DEPTH (DEPTH),
      .SW    (SW)
    ) u_match (
      .ent       (ent),
      .addr      (rd_addr[p*5 +: 5]),
      .tuse      (rd_tuse[p*2 +: 2]),
      .sel       (fwd_sel[p*SW +: SW]),
      .stall_req (port_stall[p])
    );
  end

  assign md_busy = (md_cnt != '0);
  assign stall   = (|port_stall) | (md_use & (md_busy | md_start));

  // Stage shift: E loads the decode instruction or a bubble; older stages age and W drops off
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ent <= '0;
    end else begin
      if (stall || flush_e) begin
        ent[0] <= '0;
      end else begin
        ent[0].valid <= iss_we && (iss_a3 != 5'd0);
        ent[0].a3    <= iss_a3;
        ent[0].tnew  <= iss_tnew;
      end
      for (int unsigned k = 1; k < DEPTH; k++) begin
        ent[k].valid <= ent[k-1].valid;
        ent[k].a3    <= ent[k-1].a3;
        ent[k].tnew  <= (ent[k-1].tnew != 2'd0) ? ent[k-1].tnew - 2'd1 : 2'd0;
      end
    end
  end

  // Mult/div busy counter; a start while busy is ignored
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md_cnt <= '0;
    end else if (md_start && !md_busy) begin
      md_cnt <= md_is_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
    end else if (md_busy) begin
      md_cnt <= md_cnt - 1'b1;
    end
  end

endmodule
